data_mem_p: RTL



---
 rtl/data_mem_p.sv | 105 ++++++++++
 1 files changed

// File: rtl/data_mem_p.sv
// Simple dual-port data RAM, registered read with valid strobe, write-first bypass, clear-after-reset.
// Optional macro DATA_MEM_PARITY_EN adds a stored even-parity bit per word and the par_err output.
module data_mem_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
`ifdef DATA_MEM_PARITY_EN
    ,
    output logic              par_err
`endif
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
`ifdef DATA_MEM_PARITY_EN
    logic              mem_par [DEPTH];
`endif

    logic accept, wr_ok, rd_ok, rd_in, collide;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        case (state)
            CLEAR: if (clr_cnt == LAST) state_nxt = READY;
            READY: busy = 1'b0;
            default: state_nxt = CLEAR;
        endcase
    end

    assign accept  = (state == READY);
    assign wr_ok   = accept && wr_en && ({1'b0, wr_addr} < DEPTH_L);
    assign rd_ok   = accept && rd_en;
    assign rd_in   = ({1'b0, rd_addr} < DEPTH_L);
    // Only a write that actually lands can be bypassed to the read port.
    assign collide = wr_ok && rd_en && (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
`ifdef DATA_MEM_PARITY_EN
                mem_par[clr_cnt] <= 1'b0;
`endif
            end else if (wr_ok) begin
                mem[wr_addr] <= wr_data;
`ifdef DATA_MEM_PARITY_EN
                mem_par[wr_addr] <= ^wr_data;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
            rd_valid <= rd_ok;
`ifdef DATA_MEM_PARITY_EN
            par_err  <= rd_ok && !collide && rd_in && ((^mem[rd_addr]) != mem_par[rd_addr]);
`endif
            if (rd_ok) begin
                if (collide)
                    rd_data <= wr_data;
                else if (rd_in)
                    rd_data <= mem[rd_addr];
                else
                    rd_data <= '0;
            end
        end
    end

endmodule
